// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode, flag index and queue entry definitions shared by the ALU writeback slice
package alu_pkg;

  typedef enum logic [3:0] {
    OP_SUM = 4'b0000,
    OP_SUB = 4'b0001,
    OP_INC = 4'b0010,
    OP_AND = 4'b0011,
    OP_OR  = 4'b0100,
    OP_XOR = 4'b0101,
    OP_NOT = 4'b0110,
    OP_SHL = 4'b0111,
    OP_SHR = 4'b1000,
    OP_SRA = 4'b1001
  } opcode_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Result field sized for the widest supported ALU; narrower stages zero-extend.
  localparam int RESULT_W = 32;

  typedef struct packed {
    logic [RESULT_W-1:0] result;
    logic [3:0]          flags;
    logic                illegal;
  } entry_t;

  function automatic logic is_arith(input logic [3:0] sel);
    return (sel == OP_SUM) || (sel == OP_SUB);
  endfunction

  function automatic logic is_illegal(input logic [3:0] sel);
    return sel > OP_SRA;
  endfunction

endpackage

// File: rtl/alu_wb_stage_if.sv
// rtl/alu_wb_stage_if.sv - upstream/downstream handshake and status bundle of the writeback stage
interface alu_wb_stage_if #(
  parameter int N     = 4,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_select;
  logic [N-1:0]     in_result;
  logic             in_flag_carry;
  logic             in_flag_overflow;
  logic             in_flag_negative;
  logic             in_flag_zero;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_result;
  logic [3:0]       out_flags;
  logic             out_illegal;
  logic [3:0]       sticky_flags;
  logic             sticky_clr;
  logic [CNT_W-1:0] op_count;

  modport master (
    output in_valid, in_select, in_result, in_flag_carry, in_flag_overflow,
           in_flag_negative, in_flag_zero, out_ready, sticky_clr,
    input  in_ready, out_valid, out_result, out_flags, out_illegal,
           sticky_flags, op_count
  );

  modport slave (
    input  in_valid, in_select, in_result, in_flag_carry, in_flag_overflow,
           in_flag_negative, in_flag_zero, out_ready, sticky_clr,
    output in_ready, out_valid, out_result, out_flags, out_illegal,
           sticky_flags, op_count
  );
endinterface

// File: rtl/alu_wb_fifo2.sv
// rtl/alu_wb_fifo2.sv - two-entry in-order queue of writeback entries
module alu_wb_fifo2
  import alu_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push,
  input  logic   pop,
  input  entry_t din,
  output entry_t head,
  output logic   ready,
  output logic   valid
);
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0] state;
  entry_t     mem0;
  entry_t     mem1;

  // mem0 is always the head; mem1 only holds the younger entry while FULL.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= EMPTY;
      mem0  <= '0;
      mem1  <= '0;
    end else begin
      case (state)
        EMPTY: if (push) begin
          mem0  <= din;
          state <= ONE;
        end
        ONE: begin
          if (push && pop) begin
            mem0 <= din;
          end else if (push) begin
            mem1  <= din;
            state <= FULL;
          end else if (pop) begin
            state <= EMPTY;
          end
        end
        FULL: if (pop) begin
          mem0  <= mem1;
          state <= ONE;
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign head  = mem0;
  assign ready = (state != FULL);
  assign valid = (state != EMPTY);
endmodule

// File: rtl/alu_wb_stage.sv
// rtl/alu_wb_stage.sv - ALU writeback stage: flag masking, 2-deep queue, op counter, sticky flags
// Sticky flag register is built only when ALU_WB_STICKY_EN is defined.
module alu_wb_stage
  import alu_pkg::*;
#(
  parameter int N     = 4,
  parameter int CNT_W = 8
) (
  input logic           clk,
  input logic           rst_n,
  alu_wb_stage_if.slave bus
);
  entry_t           push_entry;
  entry_t           head;
  logic             push;
  logic             pop;
  logic             fifo_ready;
  logic             fifo_valid;
  logic [3:0]       masked;
  logic [CNT_W-1:0] count;

  // Carry/overflow are only meaningful for SUM/SUB, so they are dropped otherwise.
  always_comb begin
    masked                = '0;
    masked[FLAG_N]        = bus.in_flag_negative;
    masked[FLAG_Z]        = bus.in_flag_zero;
    masked[FLAG_C]        = bus.in_flag_carry & is_arith(bus.in_select);
    masked[FLAG_V]        = bus.in_flag_overflow & is_arith(bus.in_select);
    push_entry            = '0;
    push_entry.result     = RESULT_W'(bus.in_result);
    push_entry.flags      = masked;
    push_entry.illegal    = is_illegal(bus.in_select);
  end

  assign push = bus.in_valid && fifo_ready;
  assign pop  = fifo_valid && bus.out_ready;

  alu_wb_fifo2 u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (push_entry),
    .head  (head),
    .ready (fifo_ready),
    .valid (fifo_valid)
  );

  assign bus.in_ready    = fifo_ready;
  assign bus.out_valid   = fifo_valid;
  assign bus.out_result  = head.result[N-1:0];
  assign bus.out_flags   = head.flags;
  assign bus.out_illegal = head.illegal;

  logic unused_head_result;
  assign unused_head_result = ^head.result;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (push) begin
      count <= count + CNT_W'(1);
    end
  end
  assign bus.op_count = count;

`ifdef ALU_WB_STICKY_EN
  logic [3:0] sticky;

  // A push in the same cycle as a clear leaves exactly that push's flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sticky <= '0;
    end else if (push) begin
      sticky <= (bus.sticky_clr ? 4'b0000 : sticky) | masked;
    end else if (bus.sticky_clr) begin
      sticky <= '0;
    end
  end
  assign bus.sticky_flags = sticky;
`else
  logic unused_sticky_clr;
  assign unused_sticky_clr = bus.sticky_clr;
  assign bus.sticky_flags  = '0;
`endif
endmodule
